// File: rtl/mask_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mask_seq_ctrl
// Purpose  : Walks one vector mask instruction across a mask register, one
//            32-bit word per step, through the lane's combinational mask
//            unit. Handles tail masking, cross-word sbf/sif/sof fix-ups and
//            popc/first scalar accumulation.
// Ports    : CLK, nRST (async, active-low)
//            start/op/vl/vm_masked  - launch interface, sampled in IDLE
//            busy/done              - status
//            rd_req/rd_idx/rd_ack + vs1/vs2/v0/vd words - mask RF read port
//            mu_* out / mu_* in     - mask-unit operands and results
//            wr_en/wr_idx/wr_data   - mask RF write port
//            scalar_valid/data      - popc count or first index (-1 = none)
// Revision : 1.0 - initial release
// ============================================================================
module mask_seq_ctrl #(
  parameter  int MAX_VL = 256,
  localparam int WORDS  = MAX_VL / 32,
  localparam int IDXW   = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int VLW    = $clog2(MAX_VL) + 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [VLW-1:0]  vl,
  input  logic            vm_masked,
  output logic            busy,
  output logic            done,
  output logic            rd_req,
  output logic [IDXW-1:0] rd_idx,
  input  logic            rd_ack,
  input  logic [31:0]     vs1_word,
  input  logic [31:0]     vs2_word,
  input  logic [31:0]     v0_word,
  input  logic [31:0]     vd_word,
  output logic [31:0]     mu_vs1,
  output logic [31:0]     mu_vs2,
  output logic [31:0]     mu_mask,
  output logic            mu_is_masked,
  input  logic [31:0]     mu_result,
  input  logic [5:0]      mu_popc,
  input  logic            mu_found,
  input  logic [4:0]      mu_first,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic [31:0]     wr_data,
  output logic            scalar_valid,
  output logic [31:0]     scalar_data
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ACC   = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  localparam logic [2:0] OP_POPC  = 3'd1;
  localparam logic [2:0] OP_FIRST = 3'd2;
  localparam logic [2:0] OP_SBF   = 3'd3;
  localparam logic [2:0] OP_SIF   = 3'd4;
  localparam logic [2:0] OP_SOF   = 3'd5;

  logic [2:0]      r_state, w_next;
  logic [2:0]      r_op;
  logic [VLW-1:0]  r_vl;
  logic            r_vm;
  logic [IDXW-1:0] r_word;
  logic            r_found;
  logic [31:0]     r_acc;
  logic [31:0]     r_vd;
  logic [31:0]     r_wr_data;

  logic            w_is_popc, w_is_first, w_is_scan, w_is_acc;
  logic [VLW-1:0]  w_vl_m1;
  logic [IDXW-1:0] w_last_idx;
  logic            w_last;
  logic [31:0]     w_tmask;
  logic [31:0]     w_res;
  logic [31:0]     w_merge;

  assign w_is_popc  = (r_op == OP_POPC);
  assign w_is_first = (r_op == OP_FIRST);
  assign w_is_scan  = (r_op == OP_SBF) || (r_op == OP_SIF) || (r_op == OP_SOF);
  assign w_is_acc   = w_is_popc || w_is_first;

  // Last word index = ceil(vl/32)-1; r_vl is never 0 while words are processed.
  assign w_vl_m1    = r_vl - VLW'(1);
  assign w_last_idx = IDXW'(w_vl_m1 >> 5);
  assign w_last     = (r_word == w_last_idx);

  // Only the last word can be partial; a multiple of 32 leaves it full.
  assign w_tmask = (w_last && (r_vl[4:0] != 5'd0)) ?
                   ((32'h1 << r_vl[4:0]) - 32'h1) : 32'hFFFF_FFFF;

  // Cross-word scan fix-up: words before the hit are all "before first"
  // (ones for sbf/sif, zero for sof); words after it are all zero.
  always_comb begin
    w_res = mu_result;
    if (w_is_scan) begin
      if (r_found)
        w_res = 32'h0;
      else if (!mu_found)
        w_res = (r_op == OP_SOF) ? 32'h0 : 32'hFFFF_FFFF;
    end
    w_merge = (w_res & w_tmask) | (r_vd & ~w_tmask);
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (vl == '0) ? ST_FIN : ST_FETCH;
      ST_FETCH: if (rd_ack) w_next = ST_EXEC;
      ST_EXEC:  w_next = w_is_acc ? ST_ACC : ST_WRITE;
      ST_WRITE: w_next = w_last ? ST_FIN : ST_FETCH;
      // FIRST stops reading as soon as a hit has been recorded.
      ST_ACC:   w_next = (w_last || (w_is_first && r_found)) ? ST_FIN : ST_FETCH;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_FIN);
    rd_req       = (r_state == ST_FETCH);
    wr_en        = (r_state == ST_WRITE);
    scalar_valid = (r_state == ST_FIN) && w_is_acc;
  end

  assign rd_idx       = r_word;
  assign wr_idx       = r_word;
  assign wr_data      = r_wr_data;
  assign scalar_data  = r_acc;
  assign mu_is_masked = r_vm;

  // Datapath
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_op      <= 3'd0;
      r_vl      <= '0;
      r_vm      <= 1'b0;
      r_word    <= '0;
      r_found   <= 1'b0;
      r_acc     <= 32'h0;
      r_vd      <= 32'h0;
      r_wr_data <= 32'h0;
      mu_vs1    <= 32'h0;
      mu_vs2    <= 32'h0;
      mu_mask   <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_op    <= op;
          r_vl    <= (vl > VLW'(MAX_VL)) ? VLW'(MAX_VL) : vl;
          r_vm    <= vm_masked;
          r_word  <= '0;
          r_found <= 1'b0;
          // FIRST starts at "not found" (-1) so a miss needs no final fix-up.
          r_acc   <= (op == OP_FIRST) ? 32'hFFFF_FFFF : 32'h0;
        end
        ST_FETCH: if (rd_ack) begin
          mu_vs1  <= vs1_word;
          mu_vs2  <= vs2_word & w_tmask;
          mu_mask <= v0_word;
          r_vd    <= vd_word;
        end
        ST_EXEC: begin
          if (mu_found) r_found <= 1'b1;
          if (w_is_popc)
            r_acc <= r_acc + 32'(mu_popc);
          else if (w_is_first && mu_found && !r_found)
            r_acc <= 32'({r_word, mu_first});
          r_wr_data <= w_merge;
        end
        ST_WRITE, ST_ACC: if (w_next == ST_FETCH) r_word <= r_word + IDXW'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mask_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mask_seq_ctrl
// Purpose  : Self-checking bench for mask_seq_ctrl. Provides a behavioural
//            mask unit and a mask register-file read responder; applies a
//            table of directed vectors plus reset/restart corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mask_seq_ctrl;

  localparam int MAX_VL = 256;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [2:0]  op;
  logic [8:0]  vl;
  logic        vm_masked;
  logic        busy, done, rd_req, rd_ack;
  logic [2:0]  rd_idx, wr_idx;
  logic [31:0] vs1_word, vs2_word, v0_word, vd_word;
  logic [31:0] mu_vs1, mu_vs2, mu_mask, mu_result;
  logic        mu_is_masked, mu_found;
  logic [5:0]  mu_popc;
  logic [4:0]  mu_first;
  logic        wr_en, scalar_valid;
  logic [31:0] wr_data, scalar_data;

  always #5 CLK = ~CLK;

  mask_seq_ctrl #(.MAX_VL(MAX_VL)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .vl(vl),
    .vm_masked(vm_masked), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
    .vs1_word(vs1_word), .vs2_word(vs2_word), .v0_word(v0_word),
    .vd_word(vd_word), .mu_vs1(mu_vs1), .mu_vs2(mu_vs2), .mu_mask(mu_mask),
    .mu_is_masked(mu_is_masked), .mu_result(mu_result), .mu_popc(mu_popc),
    .mu_found(mu_found), .mu_first(mu_first), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data), .scalar_valid(scalar_valid),
    .scalar_data(scalar_data)
  );

  typedef struct packed {
    logic [2:0]       op;
    logic [8:0]       vl;
    logic             vm;
    logic [7:0][31:0] vs1;
    logic [7:0][31:0] vs2;
    logic [7:0][31:0] v0;
    logic [7:0][31:0] vd;
    int               exp_nwr;
    logic [7:0][31:0] exp_wr;
    logic             exp_sv;
    logic [31:0]      exp_sc;
    int               exp_rd;
    int               exp_done;   // -1: completion cycle not checked
  } vec_t;

  vec_t vecs [16];
  vec_t cur;
  int   nvec;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural mask unit, driven by the op of the vector under test.
  logic [31:0] mu_src;
  always_comb begin
    mu_src   = mu_is_masked ? (mu_vs2 & mu_mask) : mu_vs2;
    mu_found = |mu_src;
    mu_first = 5'd0;
    mu_popc  = 6'd0;
    for (int i = 31; i >= 0; i--) if (mu_src[i]) mu_first = 5'(i);
    for (int i = 0; i < 32; i++) mu_popc = mu_popc + 6'(mu_src[i]);
    case (cur.op)
      3'd3:    mu_result = mu_found ? ((32'h1 << mu_first) - 32'h1) : 32'hFFFF_FFFF;
      3'd4:    mu_result = mu_found ? ((32'h2 << mu_first) - 32'h1) : 32'hFFFF_FFFF;
      3'd5:    mu_result = mu_found ? (32'h1 << mu_first) : 32'h0;
      default: mu_result = mu_vs1 & mu_src;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one table vector. ack_delay adds wait states before rd_ack,
  // stray drives junk rd_ack outside FETCH, restart re-pulses start mid-op.
  task automatic run_vec(input int k, input int ack_delay, input bit stray, input bit restart);
    int nrd, nwr, donecyc, wait_cnt;
    logic sv;
    logic [31:0] sc;
    logic [7:0][2:0]  wi;
    logic [7:0][31:0] wd;
    cur = vecs[k];
    nrd = 0; nwr = 0; donecyc = -1; wait_cnt = 0; sv = 1'b0; sc = 32'h0;
    wi = '0; wd = '0;
    @(negedge CLK);
    op = cur.op; vl = cur.vl; vm_masked = cur.vm; start = 1'b1;
    for (int c = 1; c <= 300 && donecyc < 0; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (restart && c == 3) begin start = 1'b1; op = 3'd1; vl = 9'd5; end
      if (wr_en) begin
        if (nwr < 8) begin wi[nwr] = wr_idx; wd[nwr] = wr_data; end
        nwr++;
      end
      if (done) begin donecyc = c; sv = scalar_valid; sc = scalar_data; end
      rd_ack = 1'b0;
      if (rd_req) begin
        if (wait_cnt >= ack_delay) begin
          rd_ack = 1'b1; wait_cnt = 0; nrd++;
          vs1_word = cur.vs1[rd_idx]; vs2_word = cur.vs2[rd_idx];
          v0_word  = cur.v0[rd_idx];  vd_word  = cur.vd[rd_idx];
        end else begin
          wait_cnt++;
        end
      end else if (stray) begin
        rd_ack = 1'b1;
        vs1_word = 32'hFFFF_FFFF; vs2_word = 32'hFFFF_FFFF;
        v0_word  = 32'hFFFF_FFFF; vd_word  = 32'hFFFF_FFFF;
      end
    end
    rd_ack = 1'b0; start = 1'b0;
    if (cur.exp_done >= 0) chk($sformatf("v%0d done_cycle", k), donecyc, cur.exp_done);
    else                   chk($sformatf("v%0d done_seen", k), 32'(donecyc > 0), 32'd1);
    chk($sformatf("v%0d nwrites", k), nwr, cur.exp_nwr);
    chk($sformatf("v%0d nreads", k), nrd, cur.exp_rd);
    for (int i = 0; i < cur.exp_nwr && i < nwr && i < 8; i++) begin
      chk($sformatf("v%0d wr_idx[%0d]", k, i), 32'(wi[i]), i);
      chk($sformatf("v%0d wr_data[%0d]", k, i), wd[i], cur.exp_wr[i]);
    end
    chk($sformatf("v%0d scalar_valid", k), 32'(sv), 32'(cur.exp_sv));
    if (cur.exp_sv) chk($sformatf("v%0d scalar_data", k), sc, cur.exp_sc);
    @(negedge CLK);
    chk($sformatf("v%0d busy_after", k), 32'(busy), 32'd0);
    chk($sformatf("v%0d done_pulse", k), 32'(done), 32'd0);
  endtask

  task automatic add(input vec_t v);
    vecs[nvec] = v;
    nvec++;
  endtask

  initial begin
    vec_t v;
    nvec = 0;
    // 0: LOGIC vl=40, partial second word merges old vd above bit 7
    v = '0; v.op = 3'd0; v.vl = 9'd40; v.exp_done = 7; v.exp_rd = 2; v.exp_nwr = 2;
    v.vs1[0] = 32'hFFFF_FFFF; v.vs1[1] = 32'hFFFF_FFFF;
    v.vs2[0] = 32'hA5A5_A5A5; v.vs2[1] = 32'h1234_5678; v.vd[1] = 32'hDEAD_BEEF;
    v.exp_wr[0] = 32'hA5A5_A5A5; v.exp_wr[1] = 32'hDEAD_BE78; add(v);
    // 1: POPC vl=64 -> 20
    v = '0; v.op = 3'd1; v.vl = 9'd64; v.exp_done = 7; v.exp_rd = 2;
    v.vs2[0] = 32'hFFFF_0000; v.vs2[1] = 32'h0000_000F; v.exp_sv = 1'b1; v.exp_sc = 32'd20; add(v);
    // 2: FIRST vl=96 -> 40, stops after word 1
    v = '0; v.op = 3'd2; v.vl = 9'd96; v.exp_done = -1; v.exp_rd = 2;
    v.vs2[1] = 32'h0000_0100; v.vs2[2] = 32'hFFFF_FFFF; v.exp_sv = 1'b1; v.exp_sc = 32'd40; add(v);
    // 3: FIRST vl=32 all zero -> -1
    v = '0; v.op = 3'd2; v.vl = 9'd32; v.exp_done = 4; v.exp_rd = 1;
    v.exp_sv = 1'b1; v.exp_sc = 32'hFFFF_FFFF; add(v);
    // 4: SIF vl=64
    v = '0; v.op = 3'd4; v.vl = 9'd64; v.exp_done = -1; v.exp_rd = 2; v.exp_nwr = 2;
    v.vs2[1] = 32'h4; v.exp_wr[0] = 32'hFFFF_FFFF; v.exp_wr[1] = 32'h7; add(v);
    // 5: SBF vl=96, word after the hit is zero
    v = '0; v.op = 3'd3; v.vl = 9'd96; v.exp_done = -1; v.exp_rd = 3; v.exp_nwr = 3;
    v.vs2[1] = 32'h10; v.vs2[2] = 32'hFF;
    v.vd[0] = 32'h5555_5555; v.vd[1] = 32'h5555_5555; v.vd[2] = 32'h5555_5555;
    v.exp_wr[0] = 32'hFFFF_FFFF; v.exp_wr[1] = 32'hF; v.exp_wr[2] = 32'h0; add(v);
    // 6: SOF vl=70, tail merge on word 2
    v = '0; v.op = 3'd5; v.vl = 9'd70; v.exp_done = -1; v.exp_rd = 3; v.exp_nwr = 3;
    v.vs2[2] = 32'h30; v.vd[0] = 32'hAAAA_AAAA; v.vd[1] = 32'hAAAA_AAAA; v.vd[2] = 32'hAAAA_AAAA;
    v.exp_wr[0] = 32'h0; v.exp_wr[1] = 32'h0; v.exp_wr[2] = 32'hAAAA_AA90; add(v);
    // 7: POPC vl=40, tail bits excluded -> 40
    v = '0; v.op = 3'd1; v.vl = 9'd40; v.exp_done = -1; v.exp_rd = 2;
    v.vs2[0] = 32'hFFFF_FFFF; v.vs2[1] = 32'hFFFF_FFFF; v.exp_sv = 1'b1; v.exp_sc = 32'd40; add(v);
    // 8: FIRST vl=40, only hits lie in the tail -> -1
    v = '0; v.op = 3'd2; v.vl = 9'd40; v.exp_done = -1; v.exp_rd = 2;
    v.vs2[1] = 32'hFFFF_FF00; v.exp_sv = 1'b1; v.exp_sc = 32'hFFFF_FFFF; add(v);
    // 9: LOGIC vl=511 clamps to 256 (8 words)
    v = '0; v.op = 3'd0; v.vl = 9'd511; v.exp_done = 25; v.exp_rd = 8; v.exp_nwr = 8;
    for (int i = 0; i < 8; i++) begin
      v.vs1[i] = 32'hFFFF_FFFF; v.vs2[i] = 32'(i + 1); v.exp_wr[i] = 32'(i + 1);
    end
    add(v);
    // 10: SIF vl=33, hit at bit 31 then one-bit tail word
    v = '0; v.op = 3'd4; v.vl = 9'd33; v.exp_done = -1; v.exp_rd = 2; v.exp_nwr = 2;
    v.vs2[0] = 32'h8000_0000; v.vs2[1] = 32'h1; v.vd[1] = 32'hF0F0_F0F0;
    v.exp_wr[0] = 32'hFFFF_FFFF; v.exp_wr[1] = 32'hF0F0_F0F0; add(v);
    // 11: reserved op 6 behaves as LOGIC
    v = '0; v.op = 3'd6; v.vl = 9'd32; v.exp_done = 4; v.exp_rd = 1; v.exp_nwr = 1;
    v.vs1[0] = 32'h0F0F_0F0F; v.vs2[0] = 32'hFF00_FF00; v.exp_wr[0] = 32'h0F00_0F00; add(v);
    // 12: SBF masked by v0
    v = '0; v.op = 3'd3; v.vl = 9'd32; v.vm = 1'b1; v.exp_done = -1; v.exp_rd = 1; v.exp_nwr = 1;
    v.vs2[0] = 32'hF0; v.v0[0] = 32'hC0; v.vd[0] = 32'hFFFF_FFFF; v.exp_wr[0] = 32'h3F; add(v);
    // 13: vl=0 completes immediately
    v = '0; v.op = 3'd0; v.vl = 9'd0; v.exp_done = 1; v.exp_rd = 0; v.exp_nwr = 0; add(v);

    cur = '0;
    nRST = 1'b0; start = 1'b0; op = 3'd0; vl = 9'd0; vm_masked = 1'b0; rd_ack = 1'b0;
    vs1_word = 32'h0; vs2_word = 32'h0; v0_word = 32'h0; vd_word = 32'h0;
    repeat (3) @(negedge CLK);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rd_req", 32'(rd_req), 32'd0);
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset scalar_valid", 32'(scalar_valid), 32'd0);
    chk("reset scalar_data", scalar_data, 32'd0);
    chk("reset mu_vs2", mu_vs2, 32'd0);
    chk("reset rd_idx", 32'(rd_idx), 32'd0);
    nRST = 1'b1;

    for (int k = 0; k < nvec; k++) run_vec(k, 0, 1'b0, 1'b0);

    // Wait states, stray acks and a start pulse while busy must not disturb SBF.
    run_vec(5, 2, 1'b1, 1'b1);
    run_vec(2, 1, 1'b1, 1'b0);

    // Reset asserted while waiting in FETCH aborts without side effects.
    begin
      int nwr_seen, done_seen;
      nwr_seen = 0; done_seen = 0;
      cur = vecs[1];
      @(negedge CLK); op = 3'd1; vl = 9'd64; start = 1'b1;
      @(negedge CLK); start = 1'b0;
      chk("abort in_fetch", 32'(rd_req), 32'd1);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort rd_req", 32'(rd_req), 32'd0);
      @(negedge CLK); nRST = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge CLK);
        if (wr_en) nwr_seen++;
        if (done || scalar_valid) done_seen++;
      end
      chk("abort no_write", nwr_seen, 0);
      chk("abort no_done", done_seen, 0);
      chk("abort idle", 32'(busy), 32'd0);
    end

    // Still operational after the abort.
    run_vec(0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mask_seq_ctrl.md
Name: mask_seq_ctrl

Overview:
- Sequencer that runs one vector mask instruction over a whole mask register, 32 bits per step, through the lane's combinational mask unit.
- For each word it fetches source words, drives the mask unit, applies tail and cross-word fix-ups, then writes the destination word or accumulates a scalar.
- Handles logical ops, popc, first, sbf, sif and sof for any vl up to MAX_VL.
- Sits between vector issue/decode and the mask register-file read/write ports.

Parameters:
- MAX_VL, 256, maximum vector length in elements (mask bits); multiple of 32.
- WORDS, MAX_VL/32, derived; number of 32-bit mask words.
- IDXW, $clog2(WORDS) (min 1), derived; width of word index.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  launch op; sampled only in IDLE.
- op  input  3  0 LOGIC, 1 POPC, 2 FIRST, 3 SBF, 4 SIF, 5 SOF; 6/7 reserved (treated as LOGIC).
- vl  input  $clog2(MAX_VL)+1  element count, latched at start.
- vm_masked  input  1  1 = masked by v0, latched at start.
- busy  output  1  high from accepted start until done inclusive.
- done  output  1  one-cycle completion pulse.
- rd_req  output  1  word read request, held until rd_ack.
- rd_idx  output  IDXW  word index requested.
- rd_ack  input  1  read data valid this cycle.
- vs1_word, vs2_word, v0_word, vd_word  input  32 each  source, mask and old-destination words; valid with rd_ack.
- mu_vs1, mu_vs2, mu_mask  output  32 each  mask-unit operands (registered words).
- mu_is_masked  output  1  equals latched vm_masked.
- mu_result  input  32  mask-unit word result (logical/sbf/sif/sof).
- mu_popc  input  6  mask-unit population count of the operand word.
- mu_found  input  1  mask-unit strobe: an active bit exists in the word.
- mu_first  input  5  index of the lowest active bit.
- wr_en  output  1  destination word write strobe.
- wr_idx  output  IDXW  word index written.
- wr_data  output  32  data written.
- scalar_valid  output  1  pulses with done for POPC/FIRST.
- scalar_data  output  32  popc count, or first index (-1 = none).

Behaviour:
- Reset: state IDLE; busy, done, rd_req, wr_en, scalar_valid = 0; rd_idx, wr_idx, scalar_data, mu_* = 0; accumulator and found flag cleared.
- States and transitions:
  - IDLE -> FETCH on start when vl>0.
  - IDLE -> FIN on start when vl==0.
  - FETCH: rd_req=1, rd_idx=word; on rd_ack, register the words -> EXEC.
  - EXEC: mask unit is combinational; sample its outputs the same cycle; apply fix-ups -> WRITE for LOGIC/SBF/SIF/SOF, or ACC for POPC/FIRST.
  - WRITE: wr_en=1 for exactly one cycle.
  - ACC: no write.
  - From WRITE or ACC: -> FETCH for the next word, or -> FIN after the last word (word == ceil(vl/32)-1).
  - FIN: done=1 for one cycle, plus scalar_valid=1 for POPC/FIRST -> IDLE.
- Latency: min 3 cycles per word plus 1 for FIN (rd_ack in the cycle after rd_req).
- Tail: tmask = vl%32==0 ? all-ones : (1<<(vl%32))-1 on the last word; all-ones on other words.
  - Operand vs2 is ANDed with tmask before the mask unit.
  - Written data = (result & tmask) | (vd_word & ~tmask).
- POPC: acc += mu_popc, 32-bit. scalar_data = acc.
- FIRST: on the first word with mu_found=1, scalar_data = word*32 + mu_first, then go straight to FIN (no further reads). If no word is found, scalar_data = 32'hFFFFFFFF.
- SBF/SIF/SOF cross-word, with a found flag set after the first word where mu_found=1:
  - Before found, a word with no active bit: SBF/SIF write all-ones, SOF writes 0.
  - The found word: mu_result is used unchanged.
  - After found: all three ops write 0.
- LOGIC: mu_result is written unchanged (subject to tail merge).
- start while busy: ignored. rd_ack outside FETCH: ignored.
- vl > MAX_VL: clamped to MAX_VL.
- nRST asserted mid-op: immediate return to IDLE; no further write, done or scalar pulse.

Test Plan:
- LOGIC, vl=40, rd_ack one cycle after each request -> two writes, idx 0 then 1. Word 1 bits [31:8] equal vd_word. done arrives 7 cycles after start.
- POPC, vl=64, vs2 = 32'hFFFF0000 and 32'h0000000F, unmasked -> scalar_data = 20 with scalar_valid and done.
- FIRST, vl=96, words 0 and 32'h00000100 and x -> scalar_data = 40; exactly 2 read requests issued.
- FIRST, vl=32, all zero -> scalar_data = 32'hFFFFFFFF.
- SIF, vl=64, words 0 and 32'h4 -> word 0 written all-ones; word 1 written 32'h00000007.
- vl=0 start -> done next cycle, no rd_req or wr_en. nRST pulsed while in FETCH -> busy=0, no write.
